// File: rtl/data_req_pkg.sv
// Shared types and default sizing for the data request master.
package data_req_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RV = 2'd2,
    RESP    = 2'd3
  } state_e;
endpackage

// File: rtl/data_req_timer.sv
// Counts WAIT_RV cycles without a completion. It flags expiry on the cycle
// whose increment brings the count to TIMEOUT.
module data_req_timer
  import data_req_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr)
      cnt <= '0;
    else if (en && cnt != CW'(TIMEOUT))
      cnt <= cnt + CW'(1);
  end

  assign expired = en && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/data_req_master.sv
// Single-outstanding request master: command in, one request/grant/rvalid
// exchange with the data responder, then one response with timeout flag.
module data_req_master
  import data_req_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_we_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_be_i,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  output logic                data_we_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o,
  output logic [DATA_W/8-1:0] data_be_o,
  input  logic                data_rvalid_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o,
  output logic                proto_err_o
);
  state_e              state, state_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                proto_q;
  logic                tmr_clr, tmr_en, tmr_expired;
  logic                proto_hit;

  data_req_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d = state;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state)
      IDLE:    if (cmd_valid_i) state_d = REQ;
      REQ:     if (data_gnt_i) begin
                 state_d = WAIT_RV;
                 tmr_clr = 1'b1;
               end
      WAIT_RV: if (data_rvalid_i) state_d = RESP;
               else begin
                 tmr_en = 1'b1;
                 if (tmr_expired) state_d = RESP;
               end
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Strobes arriving in the wrong phase (incl. rvalid after timeout) are flagged only.
    proto_hit = (data_rvalid_i && state != WAIT_RV) || (data_gnt_i && state != REQ);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state <= state_d;
      if (proto_hit) proto_q <= 1'b1;
      if (state == IDLE && cmd_valid_i) begin
        we_q    <= cmd_we_i;
        addr_q  <= cmd_addr_i;
        wdata_q <= cmd_wdata_i;
        be_q    <= cmd_be_i;
      end
      if (state == WAIT_RV) begin
        if (data_rvalid_i) begin
          rdata_q <= we_q ? '0 : data_rdata_i;
          err_q   <= 1'b0;
        end else if (tmr_expired) begin
          rdata_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

  assign cmd_ready_o  = (state == IDLE);
  assign data_req_o   = (state == REQ);
  assign data_we_o    = we_q;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = wdata_q;
  assign data_be_o    = be_q;
  assign rsp_valid_o  = (state == RESP);
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign proto_err_o  = proto_q;
endmodule
